// File: rtl/game_pkg.sv
// Shared encodings for the typing-game datapath: game states, round modes,
// target value width and the round sequencer FSM states.
package game_pkg;

   localparam int unsigned VALUE_W = 7;
   localparam int unsigned CNT_W   = 7;

   typedef enum logic [1:0] {
      GS_SELECT    = 2'd0,
      GS_COUNTDOWN = 2'd1,
      GS_INGAME    = 2'd2,
      GS_FINISH    = 2'd3
   } game_state_e;

   typedef enum logic {
      MODE_TIME = 1'b0,
      MODE_WORD = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/round_sequencer_if.sv
// Round sequencer bus: control/checker events in, frozen round results out.
interface round_sequencer_if #(
   parameter int unsigned ERR_W = 10
);
   import game_pkg::*;

   game_state_e          game_state;
   mode_e                mode;
   logic [VALUE_W-1:0]   value;
   logic                 key_valid;
   logic                 key_correct;
   logic                 word_done;
   logic                 finish;
   logic [CNT_W-1:0]     sec_left;
   logic [CNT_W-1:0]     sec_used;
   logic [CNT_W-1:0]     words;
   logic [ERR_W-1:0]     errors;
   logic [CNT_W-1:0]     streak_max;

   modport master (
      output game_state, mode, value, key_valid, key_correct, word_done,
      input  finish, sec_left, sec_used, words, errors, streak_max
   );

   modport slave (
      input  game_state, mode, value, key_valid, key_correct, word_done,
      output finish, sec_left, sec_used, words, errors, streak_max
   );
endinterface

// File: rtl/round_sequencer_sec_tick.sv
// Game-second prescaler: one-cycle tick every CLK_HZ cycles, held at zero by clr.
module sec_tick #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_c
);
   localparam int unsigned PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PS_W-1:0] cnt_q;

   assign tick_c = !clr && (cnt_q == PS_W'(CLK_HZ - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                cnt_q <= '0;
      else if (clr || tick_c)  cnt_q <= '0;
      else                     cnt_q <= cnt_q + PS_W'(1);
   end
endmodule

// File: rtl/round_sequencer.sv
// In-game round sequencer: game clock, word/error counting and round-end decision.
// Optional STREAK_EN macro builds the longest-correct-run tracker.
module round_sequencer
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned ERR_W  = 10
) (
   input  logic clk,
   input  logic rst,
   round_sequencer_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   seq_state_e         state_q, state_d;
   mode_e              mode_q;
   logic [VALUE_W-1:0] value_q;
   logic [CNT_W-1:0]   sec_left_q, sec_used_q, words_q;
   logic [ERR_W-1:0]   errors_q;
   logic               finish_q;
   logic               tick_c, time_end_c, word_end_c, timeout_c, wrong_key_c;

   sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_q != SEQ_RUN),
      .tick_c (tick_c)
   );

   // Round-end conditions; value 0 ends on the first tick / first word.
   assign time_end_c  = tick_c && (mode_q == MODE_TIME) && (sec_left_q <= CNT_W'(1));
   assign word_end_c  = bus.word_done && (mode_q == MODE_WORD) &&
                        ((8'({1'b0, words_q}) + 8'd1) >= 8'({1'b0, value_q}));
   assign timeout_c   = tick_c && (sec_used_q == CNT_MAX - CNT_W'(1));
   assign wrong_key_c = bus.key_valid && !bus.key_correct;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= SEQ_IDLE;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         finish_q <= (state_d == SEQ_DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEQ_IDLE: if (bus.game_state == GS_INGAME) state_d = SEQ_RUN;
         SEQ_RUN: begin
            if (bus.game_state != GS_INGAME)               state_d = SEQ_IDLE;
            else if (time_end_c || word_end_c || timeout_c) state_d = SEQ_DONE;
         end
         SEQ_DONE: if (bus.game_state == GS_SELECT) state_d = SEQ_IDLE;
         default:  state_d = SEQ_IDLE;
      endcase
   end

   // Round counters: reloaded in IDLE, advanced in RUN, frozen in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q     <= MODE_TIME;
         value_q    <= '0;
         sec_left_q <= '0;
         sec_used_q <= '0;
         words_q    <= '0;
         errors_q   <= '0;
      end else if (state_q == SEQ_IDLE) begin
         mode_q     <= bus.mode;
         value_q    <= bus.value;
         sec_left_q <= (bus.mode == MODE_WORD) ? '0 : CNT_W'(bus.value);
         sec_used_q <= '0;
         words_q    <= '0;
         errors_q   <= '0;
      end else if (state_q == SEQ_RUN) begin
         if (tick_c && (sec_used_q != CNT_MAX))
            sec_used_q <= sec_used_q + CNT_W'(1);
         if (tick_c && (mode_q == MODE_TIME) && (sec_left_q != '0))
            sec_left_q <= sec_left_q - CNT_W'(1);
         if (bus.word_done && (words_q != CNT_MAX))
            words_q <= words_q + CNT_W'(1);
         if (wrong_key_c && (errors_q != '1))
            errors_q <= errors_q + ERR_W'(1);
      end
   end

`ifdef STREAK_EN
   logic [CNT_W-1:0] streak_q, streak_d, streak_max_q;

   always_comb begin
      streak_d = streak_q;
      if (bus.key_valid) begin
         if (!bus.key_correct)          streak_d = '0;
         else if (streak_q != CNT_MAX)  streak_d = streak_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_q     <= '0;
         streak_max_q <= '0;
      end else if (state_q == SEQ_IDLE) begin
         streak_q     <= '0;
         streak_max_q <= '0;
      end else if (state_q == SEQ_RUN) begin
         streak_q <= streak_d;
         if (streak_d > streak_max_q) streak_max_q <= streak_d;
      end
   end

   assign bus.streak_max = streak_max_q;
`else
   assign bus.streak_max = '0;
`endif

   assign bus.finish   = finish_q;
   assign bus.sec_left = sec_left_q;
   assign bus.sec_used = sec_used_q;
   assign bus.words    = words_q;
   assign bus.errors   = errors_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a 10-cycle game second.
module tb_round_sequencer;
   import game_pkg::*;

   localparam int unsigned CLK_HZ = 10;
   localparam int unsigned ERR_W  = 10;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   round_sequencer_if #(.ERR_W(ERR_W)) bus ();

   round_sequencer #(.CLK_HZ(CLK_HZ), .ERR_W(ERR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_events();
      bus.key_valid   = 1'b0;
      bus.key_correct = 1'b0;
      bus.word_done   = 1'b0;
   endtask

   task automatic go_idle();
      clear_events();
      bus.game_state = GS_SELECT;
      step(2);
   endtask

   task automatic start_round(input mode_e m, input logic [6:0] v);
      bus.mode       = m;
      bus.value      = v;
      bus.game_state = GS_INGAME;
      step(1);
   endtask

   task automatic test_reset();
      step(2);
      total++;
      if ({bus.finish, bus.sec_left, bus.sec_used, bus.words, bus.errors, bus.streak_max} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got fin=%0b left=%0d used=%0d words=%0d err=%0d smax=%0d, want all 0",
                  bus.finish, bus.sec_left, bus.sec_used, bus.words, bus.errors, bus.streak_max);
      end
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_time_mode();
      bus.mode = MODE_TIME;
      bus.value = 7'd15;
      bus.game_state = GS_INGAME;
      step(5);
      bus.value = 7'd99;
      step(5);
      total++;
      if (bus.sec_used !== 7'd0 || bus.sec_left !== 7'd15) begin
         bad++;
         $display("FAIL time_before_tick: used=%0d left=%0d, want 0/15", bus.sec_used, bus.sec_left);
      end
      step(1);
      total++;
      if (bus.sec_used !== 7'd1 || bus.sec_left !== 7'd14) begin
         bad++;
         $display("FAIL time_first_tick: used=%0d left=%0d, want 1/14", bus.sec_used, bus.sec_left);
      end
      step(139);
      total++;
      if (bus.finish !== 1'b0 || bus.sec_left !== 7'd1) begin
         bad++;
         $display("FAIL time_pre_finish: fin=%0b left=%0d, want 0/1", bus.finish, bus.sec_left);
      end
      step(1);
      total++;
      if (bus.finish !== 1'b1 || bus.sec_left !== 7'd0 || bus.sec_used !== 7'd15) begin
         bad++;
         $display("FAIL time_finish: fin=%0b left=%0d used=%0d, want 1/0/15", bus.finish, bus.sec_left, bus.sec_used);
      end
      step(25);
      total++;
      if (bus.finish !== 1'b1 || bus.sec_used !== 7'd15) begin
         bad++;
         $display("FAIL time_frozen: fin=%0b used=%0d, want 1/15", bus.finish, bus.sec_used);
      end
      go_idle();
      total++;
      if (bus.finish !== 1'b0 || bus.sec_used !== 7'd0) begin
         bad++;
         $display("FAIL time_back_idle: fin=%0b used=%0d, want 0/0", bus.finish, bus.sec_used);
      end
   endtask

   task automatic test_word_mode();
      start_round(MODE_WORD, 7'd25);
      for (int i = 1; i <= 26; i++) begin
         bus.word_done = 1'b1;
         step(1);
         total++;
         if (bus.words !== 7'(i > 25 ? 25 : i) || bus.finish !== (i >= 25)) begin
            bad++;
            $display("FAIL word_count[%0d]: words=%0d fin=%0b, want %0d/%0b",
                     i, bus.words, bus.finish, (i > 25 ? 25 : i), (i >= 25));
         end
         bus.word_done = 1'b0;
         step(1);
      end
      go_idle();
   endtask

   task automatic test_errors();
      bit wrong_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      start_round(MODE_WORD, 7'd100);
      for (int i = 0; i < 8; i++) begin
         bus.key_valid   = 1'b1;
         bus.key_correct = !wrong_pat[i];
         bus.word_done   = (i == 0);
         step(1);
         if (i == 0) begin
            total++;
            if (bus.errors !== 10'd1 || bus.words !== 7'd1) begin
               bad++;
               $display("FAIL err_coincident: err=%0d words=%0d, want 1/1", bus.errors, bus.words);
            end
         end
      end
      clear_events();
      step(2);
      total++;
      if (bus.errors !== 10'd5 || bus.words !== 7'd1 || bus.finish !== 1'b0) begin
         bad++;
         $display("FAIL err_total: err=%0d words=%0d fin=%0b, want 5/1/0", bus.errors, bus.words, bus.finish);
      end
      go_idle();
   endtask

   task automatic test_abort();
      bit seen_finish = 1'b0;
      start_round(MODE_TIME, 7'd15);
      for (int i = 0; i < 39; i++) begin
         step(1);
         if (bus.finish) seen_finish = 1'b1;
      end
      total++;
      if (bus.sec_used !== 7'd3) begin
         bad++;
         $display("FAIL abort_progress: used=%0d, want 3", bus.sec_used);
      end
      bus.game_state = GS_SELECT;
      for (int i = 0; i < 2; i++) begin
         step(1);
         if (bus.finish) seen_finish = 1'b1;
      end
      total++;
      if (seen_finish || bus.sec_used !== 7'd0 || bus.words !== 7'd0 || bus.errors !== 10'd0 ||
          bus.sec_left !== 7'd15) begin
         bad++;
         $display("FAIL abort_cleared: seen_fin=%0b used=%0d words=%0d err=%0d left=%0d, want 0/0/0/0/15",
                  seen_finish, bus.sec_used, bus.words, bus.errors, bus.sec_left);
      end
   endtask

   task automatic test_zero_value();
      start_round(MODE_TIME, 7'd0);
      step(9);
      total++;
      if (bus.finish !== 1'b0) begin
         bad++;
         $display("FAIL zero_time_early: fin=%0b, want 0", bus.finish);
      end
      step(1);
      total++;
      if (bus.finish !== 1'b1 || bus.sec_used !== 7'd1 || bus.sec_left !== 7'd0) begin
         bad++;
         $display("FAIL zero_time_finish: fin=%0b used=%0d left=%0d, want 1/1/0", bus.finish, bus.sec_used, bus.sec_left);
      end
      go_idle();
      start_round(MODE_WORD, 7'd0);
      step(3);
      bus.word_done = 1'b1;
      step(1);
      bus.word_done = 1'b0;
      total++;
      if (bus.finish !== 1'b1 || bus.words !== 7'd1) begin
         bad++;
         $display("FAIL zero_word_finish: fin=%0b words=%0d, want 1/1", bus.finish, bus.words);
      end
      go_idle();
   endtask

   task automatic test_streak();
      logic [6:0] exp_max;
`ifdef STREAK_EN
      exp_max = 7'd6;
`else
      exp_max = 7'd0;
`endif
      start_round(MODE_WORD, 7'd100);
      for (int i = 0; i < 11; i++) begin
         bus.key_valid   = 1'b1;
         bus.key_correct = (i != 4);
         step(1);
      end
      clear_events();
      step(1);
      total++;
      if (bus.streak_max !== exp_max || bus.errors !== 10'd1) begin
         bad++;
         $display("FAIL streak_max: smax=%0d err=%0d, want %0d/1", bus.streak_max, bus.errors, exp_max);
      end
      go_idle();
   endtask

   task automatic test_timeout_reset();
      start_round(MODE_WORD, 7'd50);
      step(1269);
      total++;
      if (bus.finish !== 1'b0 || bus.sec_used !== 7'd126) begin
         bad++;
         $display("FAIL timeout_early: fin=%0b used=%0d, want 0/126", bus.finish, bus.sec_used);
      end
      step(1);
      total++;
      if (bus.finish !== 1'b1 || bus.sec_used !== 7'd127 || bus.words !== 7'd0) begin
         bad++;
         $display("FAIL timeout_finish: fin=%0b used=%0d words=%0d, want 1/127/0", bus.finish, bus.sec_used, bus.words);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({bus.finish, bus.sec_left, bus.sec_used, bus.words, bus.errors, bus.streak_max} !== '0) begin
         bad++;
         $display("FAIL reset_mid_done: fin=%0b left=%0d used=%0d words=%0d err=%0d, want all 0",
                  bus.finish, bus.sec_left, bus.sec_used, bus.words, bus.errors);
      end
      bus.game_state = GS_SELECT;
      step(1);
      rst = 1'b1;
      step(1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.game_state = GS_SELECT;
      bus.mode  = MODE_TIME;
      bus.value = 7'd0;
      clear_events();

      test_reset();
      test_time_mode();
      test_word_mode();
      test_errors();
      test_abort();
      test_zero_value();
      test_streak();
      test_timeout_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequences the in-game datapath of the typing game: once the top-level control FSM enters INGAME, this block runs the one-second game clock, counts completed words and keying errors, and decides when the round ends. It raises `finish` back to the control FSM and exposes frozen round results for the scoreboard and seven-segment display. It sits between the control FSM (game state, mode, target value) and the keystroke checker (per-key and per-word events).

## Interface
Parameters:
- CLK_HZ, 100_000_000: clock cycles per game second.
- ERR_W, 10: width of the error counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- game_state  in  2  0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
- mode  in  1  0 time mode (value = seconds), 1 word mode (value = target words).
- value  in  7  target seconds or words; sampled in IDLE.
- key_valid  in  1  one-cycle pulse per keystroke.
- key_correct  in  1  qualifies key_valid; 0 means wrong key.
- word_done  in  1  one-cycle pulse per correctly completed word.
- finish  out  1  level; high while in DONE.
- sec_left  out  7  seconds remaining (time mode), else 0.
- sec_used  out  7  elapsed seconds, saturating at 127.
- words  out  7  completed words, saturating at 127.
- errors  out  ERR_W  wrong keystrokes, saturating at all-ones.
- streak_max  out  7  longest correct-key run (only with STREAK_EN; else tied 0).

## Operation
- FSM states: IDLE, RUN, DONE. Reset: IDLE, all outputs 0.
- IDLE: every cycle load sec_left = mode ? 0 : value; latch mode and value; clear sec_used, words, errors, streak, prescaler. game_state == INGAME -> RUN next cycle.
- RUN: prescaler counts 0..CLK_HZ-1; tick when it equals CLK_HZ-1, then wraps to 0. On tick: sec_used +1 (saturating); time mode sec_left -1.
- RUN counting: word_done -> words +1; key_valid & !key_correct -> errors +1; key_valid & key_correct -> current streak +1, else on wrong key streak cleared. All events in one cycle are counted together.
- RUN -> DONE when: time mode and tick with sec_left == 1 (sec_left becomes 0); word mode and word_done with words == value-1 (words becomes value); or sec_used reaches 127 (timeout, either mode).
- RUN with game_state leaving INGAME (any value other than 2) -> IDLE (abort, no finish).
- DONE: finish = 1; all counters frozen; key/word/tick events ignored. game_state == SELECT -> IDLE.
- value == 0 in time mode: finish at first tick. value == 0 in word mode: finish at first word_done.
- Latched value/mode are used in RUN; input changes during RUN ignored.

## Timing
- RUN entered one cycle after game_state first reads INGAME.
- First tick CLK_HZ cycles after RUN entry.
- Counters update the cycle after the event; finish rises the cycle after the terminating event, in the same cycle the final count is visible.
- Reset asynchronous on assertion, synchronous release; mid-round reset returns to IDLE with all outputs 0.

## Configuration
- STREAK_EN defined: streak counter (7 bits, saturating) and streak_max register (updated when streak exceeds it) built; streak_max valid in RUN and DONE.
- STREAK_EN undefined: no streak logic; streak_max driven constant 0.

## Structure
- Shared package game_pkg: game_state encodings (SELECT/COUNTDOWN/INGAME/FINISH), mode encodings, value width (7), sequencer FSM state enum.
- One sub-module: sec_tick (prescaler with synchronous clear, emits one-cycle tick every CLK_HZ cycles).

## Test plan
Benches use CLK_HZ = 10.
- Time mode, value 15, game_state INGAME held -> tick every 10 cycles, finish rises 150 cycles after RUN entry, sec_left 0, sec_used 15.
- Word mode, value 25, 25 word_done pulses -> finish the cycle after 25th pulse, words 25; 26th pulse ignored.
- 5 key_valid with key_correct 0 plus 3 correct, word_done coincident with a wrong key -> errors 5, word counted.
- Abort: game_state INGAME -> SELECT after 40 cycles -> IDLE, finish never asserts, counters cleared.
- Word mode, no words, 1270 cycles -> timeout finish, sec_used 127; rst low mid-DONE -> all outputs 0 immediately.
- STREAK_EN: 4 correct, 1 wrong, 6 correct -> streak_max 6; without macro streak_max stays 0.
